io_port_bridge: RTL and testbench
=================================

IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter WIDTH, default 16: data word width, matching the memory-mapped IO word.
REQ-002 Parameter DEPTH, default 4: TX FIFO entries; a power of 2 and at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 out_wdata  input  WIDTH  processor value written to the output-port address.
REQ-006 out_wr  input  1  processor store to the output-port address this cycle.
REQ-007 input_IO  output  WIDTH  value presented to the processor's input-port address.
REQ-008 in_rd  input  1  processor load from the input-port address this cycle; consumes the word.
REQ-009 tx_data  output  WIDTH  word offered to the external device.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  external device accepts tx_data.
REQ-012 rx_data  input  WIDTH  word from the external device.
REQ-013 rx_valid  input  1  rx_data is valid.
REQ-014 rx_ready  output  1  bridge can accept rx_data.
REQ-015 tx_full  output  1  TX FIFO holds DEPTH entries.
REQ-016 rx_avail  output  1  a received word is held for the processor.

Function
REQ-017 The TX path SHALL be a DEPTH-entry first-word-fall-through FIFO with a log2(DEPTH)+1-bit count.
  - read and write pointers wrap modulo DEPTH.
REQ-018 tx_valid SHALL equal (count != 0), and tx_data SHALL be the head entry combinationally.
  - tx_data is 0 when the FIFO is empty.
REQ-019 A pop SHALL occur on a rising edge where tx_valid && tx_ready.
REQ-020 A push of out_wdata SHALL occur on a rising edge where out_wr && (count < DEPTH || pop).
  - simultaneous push and pop leave count unchanged, including when full.
REQ-021 out_wr while full with no pop SHALL drop the word and leave FIFO contents and count unchanged.
REQ-022 tx_full SHALL equal (count == DEPTH), registered state only.
REQ-023 Write-to-tx_valid latency SHALL be 1 cycle: pushed on edge N into an empty FIFO, visible after edge N.
REQ-024 The RX path SHALL be a two-state machine, RX_EMPTY and RX_FULL, with a WIDTH-bit holding register.
REQ-025 In RX_EMPTY, rx_ready SHALL be 1; on rx_valid, rx_data SHALL be captured and the state SHALL go to RX_FULL.
REQ-026 In RX_FULL, rx_ready SHALL be 0 and rx_avail SHALL be 1; on in_rd, the state SHALL go to RX_EMPTY.
  - rx_ready returns high the following cycle; no same-cycle refill.
REQ-027 input_IO SHALL be the holding register in RX_FULL and 0 in RX_EMPTY.
REQ-028 in_rd in RX_EMPTY SHALL have no effect.
REQ-029 TX and RX paths SHALL be fully independent; activity on one never stalls the other.

Reset
REQ-030 While reset is high at a rising edge:
  - TX count, read pointer and write pointer become 0.
  - RX state becomes RX_EMPTY; the holding register is cleared to 0.
REQ-031 After reset: tx_valid=0, tx_data=0, tx_full=0, rx_ready=1, rx_avail=0, input_IO=0.
REQ-032 Reset SHALL override simultaneous push, pop, capture or in_rd.
  - words in flight mid-transfer are discarded.

Configuration
REQ-033 With macro IO_TX_OVERFLOW_EN defined, output port tx_ovf (1 bit) SHALL exist and behave as follows:
  - it is set on the edge where a word is dropped per REQ-021.
  - it stays set until reset; it resets to 0.
REQ-034 Without IO_TX_OVERFLOW_EN, tx_ovf SHALL be absent and drops SHALL be silent.
  - all other behaviour is identical.

Verification
REQ-035 Reset, then 4 out_wr of 0x0011..0x0044 with tx_ready=0 -> tx_full=1, tx_data=0x0011; a 5th write 0x0055 is dropped; tx_ovf=1 if IO_TX_OVERFLOW_EN.
REQ-036 Full FIFO, tx_ready=1 and out_wr=0x0066 on the same edge -> count stays 4; drained order is 0x0022, 0x0033, 0x0044, 0x0066.
REQ-037 Pointer wrap: 10 writes interleaved with pops (tx_ready toggling) -> output order equals input order; count never exceeds 4.
REQ-038 rx_valid with rx_data=0xBEEF -> next cycle rx_avail=1, rx_ready=0, input_IO=0xBEEF; a second rx_valid word 0x1234 is not captured; after in_rd -> input_IO=0, rx_ready=1.
REQ-039 Reset asserted with FIFO holding 2 words and RX_FULL -> next cycle all outputs at REQ-031 values; a subsequent rx_valid is captured normally.

Source files
------------

// File: rtl/io_port_bridge_if.sv
// Processor/device-side signal bundle for io_port_bridge.
// master: processor and external device driving the bridge; slave: the bridge itself.
interface io_port_bridge_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_wdata;
    logic             out_wr;
    logic [WIDTH-1:0] input_IO;
    logic             in_rd;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             tx_full;
    logic             rx_avail;

    modport master (
        output out_wdata, out_wr, in_rd, tx_ready, rx_data, rx_valid,
        input  input_IO, tx_data, tx_valid, rx_ready, tx_full, rx_avail
    );

    modport slave (
        input  out_wdata, out_wr, in_rd, tx_ready, rx_data, rx_valid,
        output input_IO, tx_data, tx_valid, rx_ready, tx_full, rx_avail
    );
endinterface

// File: rtl/io_port_bridge.sv
// Memory-mapped IO bridge: TX FIFO from processor to device, single-word RX holding register.
// Optional macro IO_TX_OVERFLOW_EN adds a sticky tx_ovf flag for dropped TX writes.
module io_port_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    io_port_bridge_if.slave  bus
`ifdef IO_TX_OVERFLOW_EN
    ,
    output logic             tx_ovf
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {RX_EMPTY, RX_FULL} rx_state_t;

    // TX FIFO
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign bus.tx_valid = (count != '0);
    assign bus.tx_full  = (count == FULL_COUNT);
    assign bus.tx_data  = bus.tx_valid ? mem[rd_ptr] : '0;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a write then.
    assign pop  = bus.tx_valid && bus.tx_ready;
    assign push = bus.out_wr && ((count < FULL_COUNT) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.out_wdata;
    end

`ifdef IO_TX_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (reset)
            tx_ovf <= 1'b0;
        else if (bus.out_wr && !push)
            tx_ovf <= 1'b1;
    end
`endif

    // RX holding register and two-state handshake
    rx_state_t        rx_state;
    rx_state_t        rx_state_nxt;
    logic [WIDTH-1:0] rx_hold;

    always_ff @(posedge clk) begin
        if (reset)
            rx_state <= RX_EMPTY;
        else
            rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_EMPTY: if (bus.rx_valid) rx_state_nxt = RX_FULL;
            RX_FULL:  if (bus.in_rd)    rx_state_nxt = RX_EMPTY;
            default:  rx_state_nxt = RX_EMPTY;
        endcase
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        bus.rx_avail = 1'b0;
        bus.input_IO = '0;
        if (rx_state == RX_FULL) begin
            bus.rx_avail = 1'b1;
            bus.input_IO = rx_hold;
        end else begin
            bus.rx_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rx_hold <= '0;
        else if (rx_state == RX_EMPTY && bus.rx_valid)
            rx_hold <= bus.rx_data;
    end
endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge (WIDTH=16, DEPTH=4).
module tb_io_port_bridge;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    io_port_bridge_if #(.WIDTH(16)) bus ();

`ifdef IO_TX_OVERFLOW_EN
    logic tx_ovf;
    io_port_bridge #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tx_ovf(tx_ovf)
    );
`else
    io_port_bridge #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " tx_valid"}, 32'(bus.tx_valid), 0);
        check_eq({tag, " tx_data"},  32'(bus.tx_data),  0);
        check_eq({tag, " tx_full"},  32'(bus.tx_full),  0);
        check_eq({tag, " rx_ready"}, 32'(bus.rx_ready), 1);
        check_eq({tag, " rx_avail"}, 32'(bus.rx_avail), 0);
        check_eq({tag, " input_IO"}, 32'(bus.input_IO), 0);
`ifdef IO_TX_OVERFLOW_EN
        check_eq({tag, " tx_ovf"},   32'(tx_ovf),       0);
`endif
    endtask

    logic [15:0] model[$];
    logic [15:0] drain_exp [4];
    logic [15:0] head;
    int          wcount;
    int          popped;
    bit          exp_pop;
    bit          exp_push;

    initial begin
        reset         = 1'b1;
        bus.out_wdata = '0;
        bus.out_wr    = 1'b0;
        bus.in_rd     = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Fill to full with device stalled; first word visible one edge after write
        for (int i = 1; i <= 4; i++) begin
            bus.out_wr    = 1'b1;
            bus.out_wdata = 16'(i * 16'h0011);
            step();
            if (i == 1) begin
                check_eq("lat tx_valid", 32'(bus.tx_valid), 1);
                check_eq("lat tx_data",  32'(bus.tx_data),  32'h0011);
            end
        end
        check_eq("fill tx_full", 32'(bus.tx_full), 1);
        check_eq("fill tx_data", 32'(bus.tx_data), 32'h0011);
`ifdef IO_TX_OVERFLOW_EN
        check_eq("fill tx_ovf", 32'(tx_ovf), 0);
`endif
        bus.out_wdata = 16'h0055;
        step();
        check_eq("drop tx_full", 32'(bus.tx_full), 1);
        check_eq("drop tx_data", 32'(bus.tx_data), 32'h0011);
`ifdef IO_TX_OVERFLOW_EN
        check_eq("drop tx_ovf", 32'(tx_ovf), 1);
`endif

        // Push and pop on the same edge while full
        bus.out_wdata = 16'h0066;
        bus.tx_ready  = 1'b1;
        step();
        bus.out_wr = 1'b0;
        check_eq("pp tx_full", 32'(bus.tx_full), 1);
        drain_exp = '{16'h0022, 16'h0033, 16'h0044, 16'h0066};
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain[%0d]", i), 32'(bus.tx_data), 32'(drain_exp[i]));
            step();
        end
        check_eq("drained tx_valid", 32'(bus.tx_valid), 0);
        check_eq("drained tx_data",  32'(bus.tx_data),  0);

        // Pointer wrap: interleaved writes and pops against a queue model
        wcount = 0;
        popped = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (wcount >= 10 && model.size() == 0) break;
            bus.out_wr    = (wcount < 10) && (cyc % 3 != 2);
            bus.out_wdata = 16'(16'h0100 + wcount);
            bus.tx_ready  = (wcount >= 10) || (cyc % 2 == 1);
            check_eq("wrap tx_valid", 32'(bus.tx_valid), 32'(model.size() != 0));
            check_eq("wrap tx_full",  32'(bus.tx_full),  32'(model.size() == 4));
            exp_pop  = (model.size() != 0) && bus.tx_ready;
            exp_push = bus.out_wr && ((model.size() < 4) || exp_pop);
            if (exp_pop) begin
                head = model.pop_front();
                check_eq("wrap order", 32'(bus.tx_data), 32'(head));
                popped++;
            end
            if (exp_push) begin
                model.push_back(bus.out_wdata);
                wcount++;
            end
            step();
        end
        bus.out_wr   = 1'b0;
        bus.tx_ready = 1'b0;
        check_eq("wrap popped", 32'(popped), 10);
        check_eq("wrap empty",  32'(bus.tx_valid), 0);

        // RX capture, hold against a second word, consume
        bus.rx_data  = 16'hBEEF;
        bus.rx_valid = 1'b1;
        step();
        check_eq("rx avail", 32'(bus.rx_avail), 1);
        check_eq("rx ready", 32'(bus.rx_ready), 0);
        check_eq("rx data",  32'(bus.input_IO), 32'hBEEF);
        bus.rx_data = 16'h1234;
        step();
        check_eq("rx hold", 32'(bus.input_IO), 32'hBEEF);
        bus.rx_valid = 1'b0;
        bus.in_rd    = 1'b1;
        step();
        check_eq("rd input_IO", 32'(bus.input_IO), 0);
        check_eq("rd rx_ready", 32'(bus.rx_ready), 1);
        check_eq("rd rx_avail", 32'(bus.rx_avail), 0);
        step();
        bus.in_rd = 1'b0;
        check_eq("rd empty noop", 32'(bus.rx_ready), 1);

        // Both paths loaded at once, then reset with all strobes active
        bus.out_wr    = 1'b1;
        bus.out_wdata = 16'h00A1;
        bus.rx_valid  = 1'b1;
        bus.rx_data   = 16'hA5A5;
        step();
        bus.rx_valid  = 1'b0;
        bus.out_wdata = 16'h00A2;
        step();
        check_eq("pre tx_data",  32'(bus.tx_data),  32'h00A1);
        check_eq("pre input_IO", 32'(bus.input_IO), 32'hA5A5);
        bus.out_wdata = 16'h00A3;
        bus.tx_ready  = 1'b1;
        bus.rx_valid  = 1'b1;
        bus.in_rd     = 1'b1;
        reset         = 1'b1;
        step();
        reset        = 1'b0;
        bus.out_wr   = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.in_rd    = 1'b0;
        check_reset_outputs("rst2");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h5A5A;
        bus.out_wr   = 1'b1;
        bus.out_wdata = 16'h0077;
        step();
        bus.rx_valid = 1'b0;
        bus.out_wr   = 1'b0;
        check_eq("post rx",      32'(bus.input_IO), 32'h5A5A);
        check_eq("post tx_data", 32'(bus.tx_data),  32'h0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
